alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester arbiter that shares the single combinational ALU between independent clients, e.g. the execute stage and the address/branch unit. Accepts operations over valid/ready request ports and issues at most one per cycle into a registered ALU issue stage. Results and comparison flags are captured into a one-entry response slot per requester. Round-robin fairness; in-order results per requester.

## Interface
- TAG_W, 4: width of the opaque requester tag returned with each result.
- Clock  in  1  system clock, rising edge.
- Reset_n  in  1  reset; one clock, synchronous, active-low.
- ReqN_Valid  in  1  request valid, N ∈ {0,1}; held with payload stable until accepted.
- ReqN_Ready  out  1  request accepted this cycle when high with ReqN_Valid.
- ReqN_LHS, ReqN_RHS  in  32  operands.
- ReqN_Function  in  4  ALU function code, passed through unchanged.
- ReqN_Tag  in  TAG_W  tag echoed on the response.
- RspN_Valid  out  1  response slot N full.
- RspN_Ready  in  1  consumer pops slot N.
- RspN_Result  out  32  captured ALU result.
- RspN_Comparisons  out  6  captured flags {GES,GEU,LTS,LTU,NE,EQ}.
- RspN_Tag  out  TAG_W  tag of the captured operation.
- Alu_LHS, Alu_RHS  out  32  ALU operands, driven from the issue register.
- Alu_Function  out  4  ALU function, driven from the issue register.
- Alu_Result  in  32  ALU result, combinational from Alu_* outputs.
- Alu_Comparisons  in  6  ALU flags.

## Operation
- Eligibility: requester N is eligible when both conditions hold:
  - it is not the owner of a valid issue-register entry;
  - slot N is empty, or is being popped this cycle (RspN_Valid & RspN_Ready).
- Grant: among eligible requesters with ReqN_Valid, one is granted.
  - Both valid and eligible: the requester named by the priority pointer wins.
  - Only one valid and eligible: it wins regardless of the pointer.
- ReqN_Ready is high only for the granted requester. It may depend combinationally on ReqN_Valid; requesters must not make Valid depend on Ready.
- Pointer: after any grant to N, the pointer moves to the other requester. With no grant it holds.
- Accept: LHS, RHS, Function, Tag and owner are loaded into the issue register and Issue_Valid is set.
- Issue stage:
  - States: EMPTY when Issue_Valid=0, FULL when Issue_Valid=1.
  - In FULL, the Alu_* outputs carry the registered operands. At the clock edge, Alu_Result, Alu_Comparisons and the tag are written into the owner's slot.
  - A new accept in the same cycle refills the register (FULL→FULL). Otherwise it returns to EMPTY.
- Capture and pop in the same cycle on one slot: capture wins and the slot stays full with the new data. Eligibility guarantees the old entry was popped.
- In EMPTY, the Alu_* outputs hold their last values. No slot is written.
- Function codes are not decoded; unsupported codes produce whatever the ALU returns (0).

## Timing
- Accept at edge k → ALU evaluates during cycle k+1 → RspN_Valid high after edge k+1. Latency is 2 edges.
- Aggregate throughput: one op/cycle when requests alternate. A single requester is limited to one op per 2 cycles, because it is ineligible while its own op is in the issue register.
- RspN_Valid stays high, with data stable, until popped.
- Reset (Reset_n low at an edge) sets:
  - Issue_Valid=0, pointer=0;
  - both RspN_Valid=0;
  - ReqN_Ready=0 while Reset_n is low;
  - Alu_LHS/RHS/Function=0;
  - RspN_Result/Comparisons/Tag=0.
- Reset mid-operation discards the in-flight op and both slots. No response for it ever appears.

## Structure
- Shared package alu_pkg holds:
  - ALU function constants ALU_ADD=0000, ALU_SUB=1000, ALU_SLL=0001, ALU_SLT=0010, ALU_SLTU=0011, ALU_XOR=0100, ALU_SRL=0101, ALU_SRA=1101, ALU_OR=0110, ALU_AND=0111;
  - comparison-bit index constants (EQ=0 … GES=5).
- One sub-module, alu_rsp_slot: one-entry response buffer with capture/pop. It is instantiated twice.
- Arbitration, pointer and issue register live in the top.

## Test plan
- Req0 ADD 5,7 tag 3, Rsp0_Ready=1 → Rsp0_Valid 2 edges after accept; Result=12, Comparisons=6'b001110, Tag=3.
- Both requesters valid every cycle from reset, sinks ready → grants 0,1,0,1…; one response per cycle; each requester's tags in order.
- Rsp0_Ready=0, Req0 issues two ops → second op not accepted until the slot is popped; Req1 ops still accepted and completed meanwhile.
- Req1 SUB 3,5 → Result=32'hFFFFFFFE, Comparisons=6'b001110. Req1 SLTU 5,3 → Result=0, Comparisons=6'b110010.
- Reset_n low for one edge with an op in the issue register and slot 1 full → all Valid low; no late response; next simultaneous request grants Req0 first.
- Capture and pop on slot 0 in the same cycle (back-to-back Req0 with sink ready) → no lost or duplicated result; data matches the second op.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, comparison flag positions and issue-stage states.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam int unsigned CMP_EQ  = 0;
  localparam int unsigned CMP_NE  = 1;
  localparam int unsigned CMP_LTU = 2;
  localparam int unsigned CMP_LTS = 3;
  localparam int unsigned CMP_GEU = 4;
  localparam int unsigned CMP_GES = 5;
  localparam int unsigned CMP_W   = 6;

  typedef enum logic {
    ISSUE_EMPTY = 1'b0,
    ISSUE_FULL  = 1'b1
  } issue_state_t;

endpackage

// File: rtl/alu_rsp_slot.sv
// One-entry response buffer; a capture on the same edge as a pop keeps the slot full with new data.
module alu_rsp_slot
  import alu_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  logic              pop,
  input  logic [31:0]       cap_result,
  input  logic [CMP_W-1:0]  cap_flags,
  input  logic [TAG_W-1:0]  cap_tag,
  output logic              valid,
  output logic [31:0]       result,
  output logic [CMP_W-1:0]  flags,
  output logic [TAG_W-1:0]  tag
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      result <= '0;
      flags  <= '0;
      tag    <= '0;
    end else begin
      valid <= capture | (valid & ~pop);
      if (capture) begin
        result <= cap_result;
        flags  <= cap_flags;
        tag    <= cap_tag;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin two-requester front end for a shared combinational ALU with a registered issue stage.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Req0_Valid,
  output logic              Req0_Ready,
  input  logic [31:0]       Req0_LHS,
  input  logic [31:0]       Req0_RHS,
  input  logic [3:0]        Req0_Function,
  input  logic [TAG_W-1:0]  Req0_Tag,
  input  logic              Req1_Valid,
  output logic              Req1_Ready,
  input  logic [31:0]       Req1_LHS,
  input  logic [31:0]       Req1_RHS,
  input  logic [3:0]        Req1_Function,
  input  logic [TAG_W-1:0]  Req1_Tag,
  output logic              Rsp0_Valid,
  input  logic              Rsp0_Ready,
  output logic [31:0]       Rsp0_Result,
  output logic [5:0]        Rsp0_Comparisons,
  output logic [TAG_W-1:0]  Rsp0_Tag,
  output logic              Rsp1_Valid,
  input  logic              Rsp1_Ready,
  output logic [31:0]       Rsp1_Result,
  output logic [5:0]        Rsp1_Comparisons,
  output logic [TAG_W-1:0]  Rsp1_Tag,
  output logic [31:0]       Alu_LHS,
  output logic [31:0]       Alu_RHS,
  output logic [3:0]        Alu_Function,
  input  logic [31:0]       Alu_Result,
  input  logic [5:0]        Alu_Comparisons
);

  issue_state_t       state, state_next;
  logic               owner;
  logic [TAG_W-1:0]   issue_tag;
  logic               ptr;
  logic               elig0, elig1, want0, want1, grant0, grant1, accept;
  logic               cap0, cap1;

  always_ff @(posedge Clock) begin
    if (!Reset_n) state <= ISSUE_EMPTY;
    else          state <= state_next;
  end

  always_comb begin
    state_next = accept ? ISSUE_FULL : ISSUE_EMPTY;
  end

  always_comb begin
    cap0 = (state == ISSUE_FULL) && !owner;
    cap1 = (state == ISSUE_FULL) && owner;
  end

  // A requester whose op sits in the issue register is held off so its slot is never double-written.
  always_comb begin
    elig0  = !cap0 && (!Rsp0_Valid || Rsp0_Ready);
    elig1  = !cap1 && (!Rsp1_Valid || Rsp1_Ready);
    want0  = Req0_Valid && elig0;
    want1  = Req1_Valid && elig1;
    grant0 = want0 && (!want1 || !ptr);
    grant1 = want1 && (!want0 || ptr);
    accept = grant0 || grant1;
    Req0_Ready = grant0 && Reset_n;
    Req1_Ready = grant1 && Reset_n;
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      Alu_LHS      <= '0;
      Alu_RHS      <= '0;
      Alu_Function <= '0;
      issue_tag    <= '0;
      owner        <= 1'b0;
      ptr          <= 1'b0;
    end else if (accept) begin
      Alu_LHS      <= grant1 ? Req1_LHS      : Req0_LHS;
      Alu_RHS      <= grant1 ? Req1_RHS      : Req0_RHS;
      Alu_Function <= grant1 ? Req1_Function : Req0_Function;
      issue_tag    <= grant1 ? Req1_Tag      : Req0_Tag;
      owner        <= grant1;
      ptr          <= grant0;
    end
  end

  alu_rsp_slot #(.TAG_W(TAG_W)) u_slot0 (
    .clk        (Clock),
    .rst_n      (Reset_n),
    .capture    (cap0),
    .pop        (Rsp0_Ready),
    .cap_result (Alu_Result),
    .cap_flags  (Alu_Comparisons),
    .cap_tag    (issue_tag),
    .valid      (Rsp0_Valid),
    .result     (Rsp0_Result),
    .flags      (Rsp0_Comparisons),
    .tag        (Rsp0_Tag)
  );

  alu_rsp_slot #(.TAG_W(TAG_W)) u_slot1 (
    .clk        (Clock),
    .rst_n      (Reset_n),
    .capture    (cap1),
    .pop        (Rsp1_Ready),
    .cap_result (Alu_Result),
    .cap_flags  (Alu_Comparisons),
    .cap_tag    (issue_tag),
    .valid      (Rsp1_Valid),
    .result     (Rsp1_Result),
    .flags      (Rsp1_Comparisons),
    .tag        (Rsp1_Tag)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a reference combinational ALU attached to the Alu_* port.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        Req0_Valid, Req0_Ready, Req1_Valid, Req1_Ready;
  logic [31:0] Req0_LHS, Req0_RHS, Req1_LHS, Req1_RHS;
  logic [3:0]  Req0_Function, Req1_Function;
  logic [3:0]  Req0_Tag, Req1_Tag;
  logic        Rsp0_Valid, Rsp0_Ready, Rsp1_Valid, Rsp1_Ready;
  logic [31:0] Rsp0_Result, Rsp1_Result;
  logic [5:0]  Rsp0_Comparisons, Rsp1_Comparisons;
  logic [3:0]  Rsp0_Tag, Rsp1_Tag;
  logic [31:0] Alu_LHS, Alu_RHS, Alu_Result;
  logic [3:0]  Alu_Function;
  logic [5:0]  Alu_Comparisons;

  int unsigned total = 0;
  int unsigned bad   = 0;

  alu_arbiter #(.TAG_W(4)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .Req0_Valid(Req0_Valid), .Req0_Ready(Req0_Ready), .Req0_LHS(Req0_LHS), .Req0_RHS(Req0_RHS),
    .Req0_Function(Req0_Function), .Req0_Tag(Req0_Tag),
    .Req1_Valid(Req1_Valid), .Req1_Ready(Req1_Ready), .Req1_LHS(Req1_LHS), .Req1_RHS(Req1_RHS),
    .Req1_Function(Req1_Function), .Req1_Tag(Req1_Tag),
    .Rsp0_Valid(Rsp0_Valid), .Rsp0_Ready(Rsp0_Ready), .Rsp0_Result(Rsp0_Result),
    .Rsp0_Comparisons(Rsp0_Comparisons), .Rsp0_Tag(Rsp0_Tag),
    .Rsp1_Valid(Rsp1_Valid), .Rsp1_Ready(Rsp1_Ready), .Rsp1_Result(Rsp1_Result),
    .Rsp1_Comparisons(Rsp1_Comparisons), .Rsp1_Tag(Rsp1_Tag),
    .Alu_LHS(Alu_LHS), .Alu_RHS(Alu_RHS), .Alu_Function(Alu_Function),
    .Alu_Result(Alu_Result), .Alu_Comparisons(Alu_Comparisons)
  );

  always #5 Clock = ~Clock;

  always_comb begin
    case (Alu_Function)
      ALU_ADD:  Alu_Result = Alu_LHS + Alu_RHS;
      ALU_SUB:  Alu_Result = Alu_LHS - Alu_RHS;
      ALU_SLL:  Alu_Result = Alu_LHS << Alu_RHS[4:0];
      ALU_SLT:  Alu_Result = {31'd0, $signed(Alu_LHS) < $signed(Alu_RHS)};
      ALU_SLTU: Alu_Result = {31'd0, Alu_LHS < Alu_RHS};
      ALU_XOR:  Alu_Result = Alu_LHS ^ Alu_RHS;
      ALU_SRL:  Alu_Result = Alu_LHS >> Alu_RHS[4:0];
      ALU_SRA:  Alu_Result = $unsigned($signed(Alu_LHS) >>> Alu_RHS[4:0]);
      ALU_OR:   Alu_Result = Alu_LHS | Alu_RHS;
      ALU_AND:  Alu_Result = Alu_LHS & Alu_RHS;
      default:  Alu_Result = '0;
    endcase
    Alu_Comparisons = {$signed(Alu_LHS) >= $signed(Alu_RHS), Alu_LHS >= Alu_RHS,
                       $signed(Alu_LHS) < $signed(Alu_RHS), Alu_LHS < Alu_RHS,
                       Alu_LHS != Alu_RHS, Alu_LHS == Alu_RHS};
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    Req0_Valid = 1'b0; Req0_LHS = '0; Req0_RHS = '0; Req0_Function = '0; Req0_Tag = '0;
    Req1_Valid = 1'b0; Req1_LHS = '0; Req1_RHS = '0; Req1_Function = '0; Req1_Tag = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset_n = 1'b0; Req0_Valid = 1'b1; Req1_Valid = 1'b1;
    Rsp0_Ready = 1'b0; Rsp1_Ready = 1'b0;
    step(); step();
    total++; if (Req0_Ready !== 1'b0 || Req1_Ready !== 1'b0) begin bad++;
      $display("FAIL reset_ready got %b%b want 00", Req0_Ready, Req1_Ready); end
    total++; if (Rsp0_Valid !== 1'b0 || Rsp1_Valid !== 1'b0) begin bad++;
      $display("FAIL reset_rsp_valid got %b%b want 00", Rsp0_Valid, Rsp1_Valid); end
    total++; if (Alu_LHS !== 32'd0 || Alu_RHS !== 32'd0 || Alu_Function !== 4'd0) begin bad++;
      $display("FAIL reset_alu got %h %h %h want zeros", Alu_LHS, Alu_RHS, Alu_Function); end
    total++; if (Rsp0_Result !== 32'd0 || Rsp1_Comparisons !== 6'd0 || Rsp1_Tag !== 4'd0) begin bad++;
      $display("FAIL reset_rsp_data got %h %b %h want zeros", Rsp0_Result, Rsp1_Comparisons, Rsp1_Tag); end
    idle_inputs();
    Reset_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    Rsp0_Ready = 1'b1;
    Req0_Valid = 1'b1; Req0_LHS = 32'd5; Req0_RHS = 32'd7; Req0_Function = ALU_ADD; Req0_Tag = 4'd3;
    #1;
    total++; if (Req0_Ready !== 1'b1) begin bad++;
      $display("FAIL add_ready got %b want 1", Req0_Ready); end
    step();
    Req0_Valid = 1'b0;
    #1;
    total++; if (Rsp0_Valid !== 1'b0 || Alu_LHS !== 32'd5 || Alu_RHS !== 32'd7) begin bad++;
      $display("FAIL add_issue got v=%b %0d %0d want v=0 5 7", Rsp0_Valid, Alu_LHS, Alu_RHS); end
    step();
    total++; if (Rsp0_Valid !== 1'b1 || Rsp0_Result !== 32'd12 || Rsp0_Comparisons !== 6'b001110 || Rsp0_Tag !== 4'd3) begin bad++;
      $display("FAIL add_rsp got v=%b r=%0d c=%b t=%0d want v=1 r=12 c=001110 t=3",
               Rsp0_Valid, Rsp0_Result, Rsp0_Comparisons, Rsp0_Tag); end
    step();
    total++; if (Rsp0_Valid !== 1'b0) begin bad++;
      $display("FAIL add_pop got %b want 0", Rsp0_Valid); end
  endtask

  task automatic test_back_to_back();
    int unsigned n0 = 0, n1 = 0, e0 = 0, e1 = 0;
    Reset_n = 1'b0; idle_inputs(); step(); Reset_n = 1'b1;
    Rsp0_Ready = 1'b1; Rsp1_Ready = 1'b1;
    for (int unsigned cyc = 0; cyc < 12; cyc++) begin
      Req0_Valid = (n0 < 4); Req0_LHS = n0; Req0_RHS = 32'd1; Req0_Function = ALU_ADD; Req0_Tag = 4'(n0);
      Req1_Valid = (n1 < 4); Req1_LHS = 32'd100 + n1; Req1_RHS = 32'd0; Req1_Function = ALU_OR; Req1_Tag = 4'(8 + n1);
      #1;
      total++; if (Req0_Ready !== (cyc < 8 && cyc % 2 == 0) || Req1_Ready !== (cyc < 8 && cyc % 2 == 1)) begin bad++;
        $display("FAIL b2b_grant cyc=%0d got %b%b", cyc, Req0_Ready, Req1_Ready); end
      total++; if (Rsp0_Valid !== (cyc >= 2 && cyc < 10 && cyc % 2 == 0) || Rsp1_Valid !== (cyc >= 2 && cyc < 10 && cyc % 2 == 1)) begin bad++;
        $display("FAIL b2b_rsp_cycle cyc=%0d got %b%b", cyc, Rsp0_Valid, Rsp1_Valid); end
      if (Rsp0_Valid === 1'b1) begin
        total++; if (Rsp0_Tag !== 4'(e0) || Rsp0_Result !== e0 + 1) begin bad++;
          $display("FAIL b2b_rsp0 got t=%0d r=%0d want t=%0d r=%0d", Rsp0_Tag, Rsp0_Result, e0, e0 + 1); end
        e0++;
      end
      if (Rsp1_Valid === 1'b1) begin
        total++; if (Rsp1_Tag !== 4'(8 + e1) || Rsp1_Result !== 32'd100 + e1) begin bad++;
          $display("FAIL b2b_rsp1 got t=%0d r=%0d want t=%0d r=%0d", Rsp1_Tag, Rsp1_Result, 8 + e1, 100 + e1); end
        e1++;
      end
      if (Req0_Ready === 1'b1) n0++;
      if (Req1_Ready === 1'b1) n1++;
      step();
    end
    total++; if (e0 != 4 || e1 != 4) begin bad++;
      $display("FAIL b2b_count got %0d %0d want 4 4", e0, e1); end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    int unsigned n0 = 0, n1 = 0, e1 = 0;
    Rsp0_Ready = 1'b0; Rsp1_Ready = 1'b1;
    for (int unsigned cyc = 0; cyc < 9; cyc++) begin
      Req0_Valid = 1'b1; Req0_Function = ALU_ADD;
      Req0_LHS = (n0 == 0) ? 32'd1 : 32'd3; Req0_RHS = (n0 == 0) ? 32'd2 : 32'd4; Req0_Tag = (n0 == 0) ? 4'd1 : 4'd2;
      Req1_Valid = (n1 < 3); Req1_LHS = n1; Req1_RHS = n1; Req1_Function = ALU_ADD; Req1_Tag = 4'(10 + n1);
      #1;
      total++; if (Req0_Ready !== (cyc == 0)) begin bad++;
        $display("FAIL bp_req0_ready cyc=%0d got %b", cyc, Req0_Ready); end
      if (cyc >= 2) begin
        total++; if (Rsp0_Valid !== 1'b1 || Rsp0_Tag !== 4'd1 || Rsp0_Result !== 32'd3) begin bad++;
          $display("FAIL bp_hold cyc=%0d got v=%b t=%0d r=%0d want v=1 t=1 r=3", cyc, Rsp0_Valid, Rsp0_Tag, Rsp0_Result); end
      end
      if (Rsp1_Valid === 1'b1) begin
        total++; if (Rsp1_Tag !== 4'(10 + e1) || Rsp1_Result !== 2 * e1) begin bad++;
          $display("FAIL bp_rsp1 got t=%0d r=%0d want t=%0d r=%0d", Rsp1_Tag, Rsp1_Result, 10 + e1, 2 * e1); end
        e1++;
      end
      if (Req0_Ready === 1'b1) n0++;
      if (Req1_Ready === 1'b1) n1++;
      step();
    end
    total++; if (e1 != 3) begin bad++;
      $display("FAIL bp_req1_count got %0d want 3", e1); end
    Req1_Valid = 1'b0; Rsp0_Ready = 1'b1;
    #1;
    total++; if (Req0_Ready !== 1'b1) begin bad++;
      $display("FAIL bp_release got %b want 1", Req0_Ready); end
    step();
    Req0_Valid = 1'b0;
    #1;
    total++; if (Rsp0_Valid !== 1'b0) begin bad++;
      $display("FAIL bp_popped got %b want 0", Rsp0_Valid); end
    step();
    total++; if (Rsp0_Valid !== 1'b1 || Rsp0_Tag !== 4'd2 || Rsp0_Result !== 32'd7) begin bad++;
      $display("FAIL bp_second got v=%b t=%0d r=%0d want v=1 t=2 r=7", Rsp0_Valid, Rsp0_Tag, Rsp0_Result); end
    step();
    idle_inputs();
  endtask

  task automatic test_sub_sltu();
    Rsp1_Ready = 1'b1;
    Req1_Valid = 1'b1; Req1_LHS = 32'd3; Req1_RHS = 32'd5; Req1_Function = ALU_SUB; Req1_Tag = 4'd5;
    #1;
    total++; if (Req1_Ready !== 1'b1) begin bad++;
      $display("FAIL sub_ready got %b want 1", Req1_Ready); end
    step(); Req1_Valid = 1'b0; step();
    total++; if (Rsp1_Valid !== 1'b1 || Rsp1_Result !== 32'hFFFF_FFFE || Rsp1_Comparisons !== 6'b001110 || Rsp1_Tag !== 4'd5) begin bad++;
      $display("FAIL sub_rsp got v=%b r=%h c=%b t=%0d want v=1 r=fffffffe c=001110 t=5",
               Rsp1_Valid, Rsp1_Result, Rsp1_Comparisons, Rsp1_Tag); end
    Req1_Valid = 1'b1; Req1_LHS = 32'd5; Req1_RHS = 32'd3; Req1_Function = ALU_SLTU; Req1_Tag = 4'd6;
    step(); Req1_Valid = 1'b0; step();
    total++; if (Rsp1_Valid !== 1'b1 || Rsp1_Result !== 32'd0 || Rsp1_Comparisons !== 6'b110010 || Rsp1_Tag !== 4'd6) begin bad++;
      $display("FAIL sltu_rsp got v=%b r=%h c=%b t=%0d want v=1 r=0 c=110010 t=6",
               Rsp1_Valid, Rsp1_Result, Rsp1_Comparisons, Rsp1_Tag); end
    step();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    Rsp0_Ready = 1'b1; Rsp1_Ready = 1'b0;
    Req1_Valid = 1'b1; Req1_LHS = 32'd1; Req1_RHS = 32'd1; Req1_Function = ALU_ADD; Req1_Tag = 4'd9;
    step();
    Req1_Valid = 1'b0;
    Req0_Valid = 1'b1; Req0_LHS = 32'd2; Req0_RHS = 32'd2; Req0_Function = ALU_ADD; Req0_Tag = 4'd4;
    #1;
    total++; if (Req0_Ready !== 1'b1) begin bad++;
      $display("FAIL rmid_accept got %b want 1", Req0_Ready); end
    step();
    Reset_n = 1'b0;
    #1;
    total++; if (Rsp1_Valid !== 1'b1 || Req0_Ready !== 1'b0) begin bad++;
      $display("FAIL rmid_pre got rsp1=%b ready0=%b want 1 0", Rsp1_Valid, Req0_Ready); end
    step();
    Reset_n = 1'b1; Req0_Valid = 1'b0;
    for (int unsigned cyc = 0; cyc < 3; cyc++) begin
      total++; if (Rsp0_Valid !== 1'b0 || Rsp1_Valid !== 1'b0 || Rsp1_Tag !== 4'd0) begin bad++;
        $display("FAIL rmid_flush cyc=%0d got %b%b t=%0d want 00 t=0", cyc, Rsp0_Valid, Rsp1_Valid, Rsp1_Tag); end
      step();
    end
    Req0_Valid = 1'b1; Req0_Tag = 4'd1;
    Req1_Valid = 1'b1; Req1_Tag = 4'd2;
    #1;
    total++; if (Req0_Ready !== 1'b1 || Req1_Ready !== 1'b0) begin bad++;
      $display("FAIL rmid_ptr got %b%b want 10", Req0_Ready, Req1_Ready); end
    step();
    Req0_Valid = 1'b0; Rsp1_Ready = 1'b1;
    step();
    Req1_Valid = 1'b0;
    step(); step(); step();
    idle_inputs();
  endtask

  task automatic test_capture_pop();
    int unsigned n0 = 0, e0 = 0;
    Rsp0_Ready = 1'b1; Rsp1_Ready = 1'b1;
    for (int unsigned cyc = 0; cyc < 7; cyc++) begin
      Req0_Valid = (n0 < 2);
      Req0_LHS = (n0 == 0) ? 32'd10 : 32'd50; Req0_RHS = (n0 == 0) ? 32'd20 : 32'd8;
      Req0_Function = (n0 == 0) ? ALU_ADD : ALU_SUB; Req0_Tag = (n0 == 0) ? 4'd6 : 4'd7;
      #1;
      total++; if (Req0_Ready !== (cyc == 0 || cyc == 2)) begin bad++;
        $display("FAIL cp_ready cyc=%0d got %b", cyc, Req0_Ready); end
      total++; if (Rsp0_Valid !== (cyc == 2 || cyc == 4)) begin bad++;
        $display("FAIL cp_valid cyc=%0d got %b", cyc, Rsp0_Valid); end
      if (Rsp0_Valid === 1'b1) begin
        total++; if (Rsp0_Tag !== ((e0 == 0) ? 4'd6 : 4'd7) || Rsp0_Result !== ((e0 == 0) ? 32'd30 : 32'd42)) begin bad++;
          $display("FAIL cp_data got t=%0d r=%0d for entry %0d", Rsp0_Tag, Rsp0_Result, e0); end
        e0++;
      end
      if (Req0_Ready === 1'b1) n0++;
      step();
    end
    total++; if (e0 != 2) begin bad++;
      $display("FAIL cp_count got %0d want 2", e0); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_backpressure();
    test_sub_sltu();
    test_reset_mid();
    test_capture_pop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
